// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the fetch-stage instruction memory:
//   NOP_INSTR        canonical NOP (addi x0, x0, 0) used for clearing and bubbles
//   imem_state_t     controller state (self-clear vs. normal operation)
//   fetch_addr_err() misalignment / out-of-range decode of a byte PC
// -----------------------------------------------------------------------------
package imem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        IMEM_CLEAR,
        IMEM_READY
    } imem_state_t;

    // A fetch is bad when the PC is not word aligned or its word index lies
    // past the last word. The whole upper address is compared, so a large PC
    // is never aliased onto a low word.
    function automatic logic fetch_addr_err(input logic [31:0] addr,
                                            input int unsigned depth);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth);
    endfunction

endpackage

// File: rtl/imem_array.sv
// -----------------------------------------------------------------------------
// imem_array
// DEPTH x DATA_W storage with one synchronous write port and one registered,
// read-first read port.
//   clk      in   rising-edge clock
//   we       in   write enable
//   waddr    in   write word index
//   wdata    in   write data
//   rd_en    in   read enable; rdata holds its value while low
//   raddr    in   read word index
//   rdata    out  registered read data (old contents on same-index write)
// -----------------------------------------------------------------------------
module imem_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the array has no reset so it maps onto block RAM; the owner fills
    // it with a clear sequence instead. Non-blocking assignments give the
    // read-first behaviour: the read samples mem before the write lands.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (rd_en) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_sync.sv
// -----------------------------------------------------------------------------
// instr_mem_sync
// Fetch-stage instruction memory between the PC register and IF/ID. After
// every reset it fills the array with NOPs (busy high for DEPTH cycles), then
// serves 1-cycle registered fetches with stall hold and a program-load port.
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   fetch_req    in   fetch fetch_addr this cycle
//   fetch_addr   in   byte PC
//   stall        in   hold instruction/fetch_valid/fetch_err
//   instruction  out  fetched instruction (NOP for bubbles and errors)
//   fetch_valid  out  instruction is a real fetch result
//   fetch_err    out  held fetch was misaligned or out of range
//   load_we      in   program-load write enable
//   load_addr    in   program-load word index (dropped if >= DEPTH)
//   load_data    in   program-load word
//   busy         out  self-clear in progress
// -----------------------------------------------------------------------------
module instr_mem_sync
    import imem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    input  logic              stall,
    output logic [DATA_W-1:0] instruction,
    output logic              fetch_valid,
    output logic              fetch_err,
    input  logic              load_we,
    input  logic [IDX_W-1:0]  load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              busy
);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_INSTR);

    imem_state_t       state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    // Output shows array data when set, otherwise NOP (bubble / error / reset).
    logic              sel_mem_q, sel_mem_d;

    logic              addr_err;
    logic [IDX_W-1:0]  fetch_idx;
    logic              load_in_range;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;

    assign addr_err      = fetch_addr_err(fetch_addr, DEPTH);
    assign fetch_idx     = fetch_addr[IDX_W+1:2];
    assign load_in_range = 32'(load_addr) < 32'(DEPTH);

    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        err_d     = err_q;
        sel_mem_d = sel_mem_q;
        mem_we    = 1'b0;
        mem_waddr = clr_cnt_q;
        mem_wdata = NOP_WORD;
        mem_rd_en = 1'b0;

        unique case (state_q)
            IMEM_CLEAR: begin
                // Loads and fetches are ignored until the array is filled.
                mem_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + IDX_W'(1);
                valid_d   = 1'b0;
                err_d     = 1'b0;
                sel_mem_d = 1'b0;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = IMEM_READY;
                    busy_d    = 1'b0;
                    clr_cnt_d = '0;
                end
            end
            IMEM_READY: begin
                if (load_we && load_in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = load_addr;
                    mem_wdata = load_data;
                end
                // Stall wins over fetch_req: every output register holds, and
                // the array read is not enabled so its data holds as well.
                if (!stall) begin
                    if (fetch_req) begin
                        valid_d   = 1'b1;
                        err_d     = addr_err;
                        sel_mem_d = !addr_err;
                        mem_rd_en = !addr_err;
                    end else begin
                        valid_d   = 1'b0;
                        err_d     = 1'b0;
                        sel_mem_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IMEM_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IMEM_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            sel_mem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            sel_mem_q <= sel_mem_d;
        end
    end

    // Writes are suppressed on a reset edge so an aborted clear or load never
    // lands; the clear restarts from index 0 on the next cycle.
    imem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we && rst_n),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .rd_en (mem_rd_en && rst_n),
        .raddr (fetch_idx),
        .rdata (mem_rdata)
    );

    assign instruction = sel_mem_q ? mem_rdata : NOP_WORD;
    assign fetch_valid = valid_q;
    assign fetch_err   = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_sync
// Directed bench for instr_mem_sync with DEPTH=256. Inputs change 1 time unit
// after a rising edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_instr_mem_sync;

    localparam int          DEPTH = 256;
    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              stall;
    logic [31:0]       instruction;
    logic              fetch_valid;
    logic              fetch_err;
    logic              load_we;
    logic [IDX_W-1:0]  load_addr;
    logic [31:0]       load_data;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    instr_mem_sync #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .stall       (stall),
        .instruction (instruction),
        .fetch_valid (fetch_valid),
        .fetch_err   (fetch_err),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Runs rising edges until busy drops (bounded), returning the edge count
    // and whether fetch_valid was ever seen high while busy.
    task automatic wait_clear(output int edges, output logic saw_valid);
        edges     = 0;
        saw_valid = 1'b0;
        while (busy === 1'b1 && edges < 400) begin
            if (fetch_valid !== 1'b0) saw_valid = 1'b1;
            step();
            edges++;
        end
    endtask

    int   edges;
    logic saw_valid;

    initial begin
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = 32'h0;
        stall      = 1'b0;
        load_we    = 1'b0;
        load_addr  = '0;
        load_data  = 32'h0;

        // ---- reset state
        step();
        check("rst_busy",  32'(busy), 32'd1);
        check("rst_valid", 32'(fetch_valid), 32'd0);
        check("rst_err",   32'(fetch_err), 32'd0);
        check("rst_instr", instruction, NOP);

        // ---- 1: self-clear lasts DEPTH cycles, fetches ignored meanwhile
        rst_n      = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        wait_clear(edges, saw_valid);
        check("clear_cycles", 32'(edges), 32'd256);
        check("clear_no_valid", 32'(saw_valid), 32'd0);
        check("clear_end_valid", 32'(fetch_valid), 32'd0);
        step();
        check("first_instr", instruction, NOP);
        check("first_valid", 32'(fetch_valid), 32'd1);
        check("first_err",   32'(fetch_err), 32'd0);

        // ---- 2: load then fetch, plus a bubble in between
        fetch_req = 1'b0;
        load_we   = 1'b1;
        load_addr = IDX_W'(1);
        load_data = 32'h0010_0113;
        step();
        load_we = 1'b0;
        check("bubble_valid", 32'(fetch_valid), 32'd0);
        check("bubble_instr", instruction, NOP);
        fetch_req  = 1'b1;
        fetch_addr = 32'h4;
        step();
        check("load_fetch_instr", instruction, 32'h0010_0113);
        check("load_fetch_valid", 32'(fetch_valid), 32'd1);
        check("load_fetch_err",   32'(fetch_err), 32'd0);

        // ---- 3: stall holds outputs for three cycles
        stall      = 1'b1;
        fetch_addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_instr", instruction, 32'h0010_0113);
            check("stall_valid", 32'(fetch_valid), 32'd1);
        end
        stall = 1'b0;
        step();
        check("unstall_instr", instruction, NOP);
        check("unstall_valid", 32'(fetch_valid), 32'd1);

        // ---- 4: error decode
        fetch_addr = 32'h6;
        step();
        check("misalign_err",   32'(fetch_err), 32'd1);
        check("misalign_valid", 32'(fetch_valid), 32'd1);
        check("misalign_instr", instruction, NOP);
        fetch_addr = 32'h400;
        step();
        check("range_err", 32'(fetch_err), 32'd1);
        check("range_instr", instruction, NOP);
        fetch_addr = 32'h8000_0004;  // would alias onto word 1 if truncated
        step();
        check("high_err", 32'(fetch_err), 32'd1);
        check("high_instr", instruction, NOP);
        fetch_addr = 32'h3FC;
        step();
        check("last_err",   32'(fetch_err), 32'd0);
        check("last_valid", 32'(fetch_valid), 32'd1);
        check("last_instr", instruction, NOP);

        // ---- 5: read-during-write returns old data
        load_we    = 1'b1;
        load_addr  = IDX_W'(2);
        load_data  = 32'hDEAD_BEEF;
        fetch_addr = 32'h8;
        step();
        load_we = 1'b0;
        check("rdw_old", instruction, NOP);
        step();
        check("rdw_new", instruction, 32'hDEAD_BEEF);

        // ---- 6: reset mid-clear restarts the full clear
        load_we    = 1'b1;
        load_addr  = IDX_W'(3);
        load_data  = 32'h1234_5678;
        fetch_addr = 32'hC;
        step();
        load_we = 1'b0;
        step();
        check("pre_reset_load", instruction, 32'h1234_5678);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) step();
        check("mid_clear_busy", 32'(busy), 32'd1);
        check("mid_clear_valid", 32'(fetch_valid), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_clear(edges, saw_valid);
        check("reclear_cycles", 32'(edges), 32'd256);
        check("reclear_no_valid", 32'(saw_valid), 32'd0);
        step();
        check("cleared_3_instr", instruction, NOP);
        check("cleared_3_valid", 32'(fetch_valid), 32'd1);
        fetch_addr = 32'h4;
        step();
        check("cleared_1_instr", instruction, NOP);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
